// File: rtl/spi_mosi_byte_tx_if.sv
// Byte-level handshake and serial-line bundle for the SSD1331 MOSI transmitter.
// The upstream producer uses the master view; the transmitter uses the slave view.
interface spi_mosi_byte_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] i_DATA;
    logic             i_START;
    logic             i_DC;
    logic             o_MOSI;
    logic             o_SCLK_EN;
    logic             o_CS_N;
    logic             o_DC;
    logic             o_BUSY;
    logic             o_BYTE_DONE;

    modport master (
        output i_DATA,
        output i_START,
        output i_DC,
        input  o_MOSI,
        input  o_SCLK_EN,
        input  o_CS_N,
        input  o_DC,
        input  o_BUSY,
        input  o_BYTE_DONE
    );

    modport slave (
        input  i_DATA,
        input  i_START,
        input  i_DC,
        output o_MOSI,
        output o_SCLK_EN,
        output o_CS_N,
        output o_DC,
        output o_BUSY,
        output o_BYTE_DONE
    );
endinterface

// File: rtl/spi_mosi_byte_tx.sv
// MSB-first byte serializer for the SSD1331 SPI link. Streams back-to-back bytes
// with no gap while i_START stays high, then holds CS low for CS_HOLD cycles.
module spi_mosi_byte_tx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CS_HOLD = 2
) (
    input logic               i_SCK,
    input logic               i_RST,
    spi_mosi_byte_tx_if.slave bus_io
);
    localparam int unsigned     CntW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
    localparam logic [3:0]      HoldInit = 4'(CS_HOLD - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    if (CS_HOLD < 1 || CS_HOLD > 15) begin : g_bad_cs_hold
        $error("CS_HOLD must be in 1..15");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             mosi_q, mosi_d;
    logic             sclk_en_q, sclk_en_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;
    logic             done_q, done_d;

    logic last_bit;
    logic load;

    // A new byte is accepted from IDLE, or on the last-bit edge for zero-gap streaming.
    always_comb begin
        last_bit = (state_q == StShift) && (bit_cnt_q == LastBit);
        load     = bus_io.i_START && ((state_q == StIdle) || last_bit);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        mosi_d     = mosi_q;
        sclk_en_d  = sclk_en_q;
        cs_n_d     = cs_n_q;
        dc_d       = dc_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Outputs hold; a pending i_START is handled by the load path below.
            end
            StShift: begin
                if (!last_bit) begin
                    sr_d      = sr_q << 1;
                    mosi_d    = sr_q[WIDTH-2];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (!load) begin
                        sclk_en_d  = 1'b0;
                        mosi_d     = 1'b0;
                        hold_cnt_d = HoldInit;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                // i_START is deliberately not looked at here.
                if (hold_cnt_q == 4'd0) begin
                    cs_n_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            sr_d      = bus_io.i_DATA;
            mosi_d    = bus_io.i_DATA[WIDTH-1];
            dc_d      = bus_io.i_DC;
            cs_n_d    = 1'b0;
            sclk_en_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = StShift;
        end
    end

    // State and output registers; reset aborts any byte in flight.
    always_ff @(posedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            mosi_q     <= 1'b0;
            sclk_en_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            dc_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            mosi_q     <= mosi_d;
            sclk_en_q  <= sclk_en_d;
            cs_n_q     <= cs_n_d;
            dc_q       <= dc_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.o_MOSI      = mosi_q;
    assign bus_io.o_SCLK_EN   = sclk_en_q;
    assign bus_io.o_CS_N      = cs_n_q;
    assign bus_io.o_DC        = dc_q;
    assign bus_io.o_BYTE_DONE = done_q;
    assign bus_io.o_BUSY      = (state_q != StIdle);
endmodule

// File: doc/spi_mosi_byte_tx.md
SPI_MOSI_BYTE_TX -- requirements
Module: spi_mosi_byte_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per serial byte, sent MSB first.
REQ-002 SHALL have parameter CS_HOLD, default 2, i_SCK cycles o_CS_N stays low after the last bit of a burst; legal range 1..15.
REQ-003 SHALL have port i_SCK  input  1  single system/bit clock; all state updates on its rising edge.
REQ-004 SHALL have port i_RST  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port i_DATA  input  WIDTH  byte to serialize, sampled on load edges only.
REQ-006 SHALL have port i_START  input  1  high = a byte is available on i_DATA/i_DC.
REQ-007 SHALL have port i_DC  input  1  data/command flag for the byte on i_DATA.
REQ-008 SHALL have port o_MOSI  output  1  serial data to the SSD1331.
REQ-009 SHALL have port o_SCLK_EN  output  1  high while o_MOSI carries a valid bit; top level gates/forwards the SPI clock with it.
REQ-010 SHALL have port o_CS_N  output  1  active-low chip select.
REQ-011 SHALL have port o_DC  output  1  D/C line, held for the whole byte.
REQ-012 SHALL have port o_BUSY  output  1  high in any state other than IDLE.
REQ-013 SHALL have port o_BYTE_DONE  output  1  one-cycle pulse per completed byte.

Function
REQ-014 SHALL implement states IDLE, SHIFT and HOLD, plus a WIDTH-bit shift register and a bit counter of clog2(WIDTH) bits.
REQ-015 In IDLE with i_START=1, the edge SHALL: load shift reg from i_DATA; set o_MOSI=i_DATA[WIDTH-1], o_DC=i_DC, o_CS_N=0, o_SCLK_EN=1, bit count=0; go to SHIFT.
REQ-016 In IDLE with i_START=0, outputs SHALL hold their idle values.
REQ-017 In SHIFT with bit count < WIDTH-1, each edge SHALL left-shift, drive the next lower bit on o_MOSI and increment the count; o_DC SHALL NOT change mid-byte.
REQ-018 In SHIFT with bit count = WIDTH-1, i.e. the last bit driven, the next edge SHALL pulse o_BYTE_DONE=1 for one cycle.
REQ-019 At that same edge, if i_START=1, the block SHALL load the new byte exactly as in REQ-015 and stay in SHIFT: zero-gap streaming, o_CS_N and o_SCLK_EN stay asserted.
REQ-020 At that same edge, if i_START=0, the block SHALL set o_SCLK_EN=0, o_MOSI=0, load the hold counter with CS_HOLD-1 and go to HOLD.
REQ-021 In HOLD, o_CS_N SHALL stay 0 and the counter SHALL decrement each edge; at count 0 the edge SHALL set o_CS_N=1 and go to IDLE.
REQ-022 i_START in HOLD SHALL be ignored; it is sampled again only in IDLE, and upstream keeps it asserted until accepted.
REQ-023 Each byte SHALL occupy exactly WIDTH consecutive cycles with o_SCLK_EN=1; per-byte latency from the load edge to the o_BYTE_DONE edge SHALL be WIDTH cycles.
REQ-024 o_BUSY SHALL be combinationally (state != IDLE).
REQ-025 i_DATA/i_DC changes between load edges SHALL have no effect on the byte in flight.
REQ-026 All outputs other than o_BUSY SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 While i_RST=0, regardless of clock: state=IDLE, o_MOSI=0, o_SCLK_EN=0, o_CS_N=1, o_DC=0, o_BYTE_DONE=0, o_BUSY=0, counters and shift reg 0.
REQ-028 Reset asserted mid-byte or in HOLD SHALL abort immediately with no partial o_BYTE_DONE; the first load is allowed on the first rising edge after i_RST returns to 1.

Verification
REQ-029 Single byte: i_DATA=8'hA5, i_DC=0, i_START for 1 cycle -> o_MOSI 1,0,1,0,0,1,0,1 over 8 cycles with o_SCLK_EN=1, o_BYTE_DONE pulse at cycle 8, o_CS_N low 8+2 cycles, then high.
REQ-030 Streaming: bytes 8'h81 (DC=0) then 8'h3C (DC=1), i_START held -> 16 contiguous SCLK_EN cycles, o_DC changes 0->1 exactly at bit 0 of the second byte, two BYTE_DONE pulses 8 cycles apart.
REQ-031 Reset mid-byte: assert i_RST=0 during bit 4 of 8'hFF -> o_CS_N=1 and o_SCLK_EN=0 immediately, no BYTE_DONE; next byte after release transmits intact.
REQ-032 i_START asserted during HOLD -> ignored until IDLE, then accepted; o_CS_N shows a 1-cycle high gap.
REQ-033 i_DATA toggled every cycle during a transfer -> serialized bits match only the value sampled at the load edge.
REQ-034 CS_HOLD=1 and WIDTH=16 builds: hold length 1 cycle, 16-bit frames MSB first, BYTE_DONE after 16 cycles.
